// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO port plus valid/ready output stream used by fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             fifo_empty;
   logic             fifo_rden;
   logic [WIDTH-1:0] fifo_rddata;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      input  fifo_empty, fifo_rddata, out_ready,
      output fifo_rden, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_rddata, out_ready,
      input  fifo_rden, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side framer: header, BURST data words, footer with sequence number.
// Optional early frame close on a starved FIFO: define FIFO_RD_CTRL_TIMEOUT_EN.
module fifo_rd_ctrl #(
   parameter int          WIDTH   = 64,
   parameter int          BURST   = 256,
   parameter logic [63:0] HEADER  = 64'hA5A5_5A5A_F00D_CAFE,
   parameter int          TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   output logic           busy,
   fifo_rd_ctrl_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_FOOTER} state_t;

   localparam int               CNT_W = $clog2(BURST + 1);
   localparam logic [WIDTH-1:0] HDR_W = WIDTH'(HEADER);

   if (WIDTH < 32) begin : g_chk_width
      $error("fifo_rd_ctrl: WIDTH must be at least 32");
   end
   if (BURST < 1) begin : g_chk_burst
      $error("fifo_rd_ctrl: BURST must be at least 1");
   end
   if (TIMEOUT < 1) begin : g_chk_timeout
      $error("fifo_rd_ctrl: TIMEOUT must be at least 1");
   end

   function automatic logic [WIDTH-1:0] footer_word(input logic [15:0] s, input logic sh);
      footer_word = {~HDR_W[WIDTH-1:17], sh, s};
   endfunction

   state_t           state, state_nxt;
   logic [CNT_W-1:0] req_cnt, acc_cnt;
   logic [1:0]       buf_cnt;
   logic             buf_rd_ptr, buf_wr_ptr;
   logic [WIDTH-1:0] buf_data_p2 [2];
   logic             rd_vld_p1;
   logic [15:0]      seq;
   logic             short_flag;
   logic             out_valid_c, out_last_c;
   logic [WIDTH-1:0] out_data_c;
   logic             accept, pop, rden, frame_close, frame_start;
   logic [2:0]       occ_nxt;

   assign accept      = out_valid_c && bus.out_ready;
   assign pop         = (state == S_DATA) && accept;
   assign frame_start = (state == S_IDLE) && (state_nxt == S_HEADER);
   assign frame_close = (pop && acc_cnt == CNT_W'(BURST - 1)) ||
                        (short_flag && buf_cnt == 2'd0 && !rd_vld_p1);

   // Occupancy counts this cycle's accept so a word leaving frees its slot at once,
   // which keeps one read per cycle going with the sink always ready.
   assign occ_nxt = 3'(buf_cnt) + 3'(rd_vld_p1) - 3'(pop);
   assign rden    = !rst && !bus.fifo_empty && (occ_nxt < 3'd2) &&
                    (req_cnt < CNT_W'(BURST)) && !short_flag &&
                    (state == S_HEADER || state == S_DATA);

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != S_DATA || accept)
         to_cnt <= '0;
      else if (buf_cnt == 2'd0 && bus.fifo_empty && to_cnt != TO_W'(TIMEOUT))
         to_cnt <= to_cnt + TO_W'(1);
   end

   // Sticky for the rest of the frame so draining accepts do not restart reads.
   always_ff @(posedge clk) begin
      if (rst || state == S_IDLE)
         short_flag <= 1'b0;
      else if (state == S_DATA && to_cnt == TO_W'(TIMEOUT))
         short_flag <= 1'b1;
   end
`else
   assign short_flag = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      out_valid_c = 1'b0;
      out_data_c  = '0;
      out_last_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && !bus.fifo_empty) state_nxt = S_HEADER;
         end
         S_HEADER: begin
            out_valid_c = 1'b1;
            out_data_c  = HDR_W;
            if (bus.out_ready) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (buf_cnt != 2'd0) begin
               out_valid_c = 1'b1;
               out_data_c  = buf_data_p2[buf_rd_ptr];
            end
            if (frame_close) state_nxt = S_FOOTER;
         end
         S_FOOTER: begin
            out_valid_c = 1'b1;
            out_data_c  = footer_word(seq, short_flag);
            out_last_c  = 1'b1;
            if (bus.out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         req_cnt    <= '0;
         acc_cnt    <= '0;
         buf_cnt    <= 2'd0;
         buf_rd_ptr <= 1'b0;
         buf_wr_ptr <= 1'b0;
         rd_vld_p1  <= 1'b0;
         seq        <= 16'd0;
      end else begin
         state     <= state_nxt;
         rd_vld_p1 <= rden;
         if (frame_start)  req_cnt <= '0;
         else if (rden)    req_cnt <= req_cnt + CNT_W'(1);
         if (frame_start)  acc_cnt <= '0;
         else if (pop)     acc_cnt <= acc_cnt + CNT_W'(1);
         if (rd_vld_p1)    buf_wr_ptr <= ~buf_wr_ptr;
         if (pop)          buf_rd_ptr <= ~buf_rd_ptr;
         buf_cnt <= 2'(3'(buf_cnt) + 3'(rd_vld_p1) - 3'(pop));
         if (state == S_FOOTER && accept) seq <= seq + 16'd1;
      end
   end

   // p1 -> p2: FIFO read data lands in the skid buffer one cycle after the read
   always_ff @(posedge clk) begin
      if (rd_vld_p1) buf_data_p2[buf_wr_ptr] <= bus.fifo_rddata;
   end

   assign bus.fifo_rden = rden;
   assign bus.out_valid = out_valid_c;
   assign bus.out_data  = out_data_c;
   assign bus.out_last  = out_last_c;
   assign busy          = (state != S_IDLE);

endmodule
